// File: rtl/sar_search_4bit.sv
// Successive-approximation search that recovers an external value via a comparator.
// Define SAR_EARLY_EXIT_EN to stop as soon as the comparator reports equality.
module sar_search_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] probe,
    output logic             probe_valid,
    input  logic             a_gt_b,
    input  logic             a_lt_b,
    input  logic             a_eq_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             error
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0]    K_TOP   = KW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] TOP_BIT = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] probe_q;
    logic             probe_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    logic [WIDTH-1:0] kmask;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] probe_d;
    logic             resp_onehot;
    logic             finish;

    always_comb begin
        kmask        = '0;
        kmask[k_q]   = 1'b1;
        resp_onehot  = ({a_gt_b, a_lt_b, a_eq_b} == 3'b100) ||
                       ({a_gt_b, a_lt_b, a_eq_b} == 3'b010) ||
                       ({a_gt_b, a_lt_b, a_eq_b} == 3'b001);
        // The bit decision looks at a_lt_b alone, even for malformed responses.
        result_d     = a_lt_b ? result_q : (result_q | kmask);
        probe_d      = result_d | (kmask >> 1);
        finish       = (k_q == '0);
`ifdef SAR_EARLY_EXIT_EN
        // Lower bits are still clear here, so result_d is already the final value.
        if (resp_onehot && a_eq_b)
            finish = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= K_TOP;
            result_q      <= '0;
            probe_q       <= '0;
            probe_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q       <= SEARCH;
                        k_q           <= K_TOP;
                        result_q      <= '0;
                        error_q       <= 1'b0;
                        probe_q       <= TOP_BIT;
                        probe_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                SEARCH: begin
                    result_q <= result_d;
                    if (!resp_onehot)
                        error_q <= 1'b1;
                    if (finish) begin
                        state_q       <= DONE;
                        probe_q       <= '0;
                        probe_valid_q <= 1'b0;
                        done_q        <= 1'b1;
                    end else begin
                        k_q     <= k_q - KW'(1);
                        probe_q <= probe_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    k_q     <= K_TOP;
                end
                default: begin
                    state_q       <= IDLE;
                    probe_q       <= '0;
                    probe_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b0;
                end
            endcase
        end
    end

    assign probe       = probe_q;
    assign probe_valid = probe_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign error       = error_q;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Directed bench for sar_search_4bit with a behavioural comparator on the probe bus.
module tb_sar_search_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] probe;
    logic       probe_valid;
    logic       a_gt_b, a_lt_b, a_eq_b;
    logic       busy, done, error;
    logic [3:0] result;

    logic [3:0] a_val;
    logic       force_bad;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // External comparator; force_bad produces a non-one-hot gt+lt response.
    always_comb begin
        a_gt_b = (a_val > probe) || force_bad;
        a_lt_b = (a_val < probe) || force_bad;
        a_eq_b = (a_val == probe) && !force_bad;
    end

    sar_search_4bit #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .probe(probe), .probe_valid(probe_valid),
        .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b),
        .busy(busy), .done(done), .result(result), .error(error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [3:0] exp_r, input logic exp_err);
        chk({tag, ".probe"}, {4'h0, probe}, 8'h00);
        chk({tag, ".valid"}, {7'h0, probe_valid}, 8'h00);
        chk({tag, ".busy"}, {7'h0, busy}, 8'h00);
        chk({tag, ".done"}, {7'h0, done}, 8'h00);
        chk({tag, ".result"}, {4'h0, result}, {4'h0, exp_r});
        chk({tag, ".error"}, {7'h0, error}, {7'h0, exp_err});
    endtask

    // probes holds expected probes MSB-nibble first; start_at/bad_at name the probe index
    // (0-based) during which start is re-pulsed or the response is corrupted (-1 = never).
    task automatic run(input string tag, input logic [3:0] av, input int n,
                       input logic [15:0] probes, input logic [3:0] exp_r,
                       input logic exp_err, input int start_at, input int bad_at);
        logic [15:0] pv;
        pv    = probes;
        a_val = av;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.probe%0d", tag, i), {4'h0, probe}, {4'h0, pv[15:12]});
            chk($sformatf("%s.valid%0d", tag, i), {7'h0, probe_valid}, 8'h01);
            chk($sformatf("%s.busy%0d", tag, i), {7'h0, busy}, 8'h01);
            chk($sformatf("%s.done%0d", tag, i), {7'h0, done}, 8'h00);
            if (i == 0)
                chk({tag, ".errclr"}, {7'h0, error}, 8'h00);
            pv = pv << 4;
            if (i == start_at) start = 1'b1;
            if (i == bad_at) force_bad = 1'b1;
            tick();
            start     = 1'b0;
            force_bad = 1'b0;
        end
        chk({tag, ".done"}, {7'h0, done}, 8'h01);
        chk({tag, ".dbusy"}, {7'h0, busy}, 8'h01);
        chk({tag, ".dvalid"}, {7'h0, probe_valid}, 8'h00);
        chk({tag, ".result"}, {4'h0, result}, {4'h0, exp_r});
        chk({tag, ".error"}, {7'h0, error}, {7'h0, exp_err});
        tick();
        chk_idle({tag, ".after"}, exp_r, exp_err);
        tick();
        chk_idle({tag, ".hold"}, exp_r, exp_err);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        a_val     = 4'h0;
        force_bad = 1'b0;
        #1;
        chk_idle("rst0", 4'h0, 1'b0);
        tick();
        tick();
        chk_idle("rst1", 4'h0, 1'b0);
        rst = 1'b0;

        run("a0",  4'h0, 4, 16'h8421, 4'h0, 1'b0, -1, -1);
        run("a15", 4'hF, 4, 16'h8CEF, 4'hF, 1'b0, -1, -1);
`ifdef SAR_EARLY_EXIT_EN
        run("a8",  4'h8, 1, 16'h8000, 4'h8, 1'b0, -1, -1);
`else
        run("a8",  4'h8, 4, 16'h8CA9, 4'h8, 1'b0, -1, -1);
`endif
        run("a5",  4'h5, 4, 16'h8465, 4'h5, 1'b0, -1, -1);
        run("busy_start", 4'hB, 4, 16'h8CAB, 4'hB, 1'b0, 1, -1);
        tick();
        chk_idle("noqueue", 4'hB, 1'b0);

        run("bad", 4'hB, 4, 16'h8CAB, 4'hB, 1'b1, -1, 1);
        run("errclr", 4'h3, 4, 16'h8423, 4'h3, 1'b0, -1, -1);

        // Abort during the third probe of a=5 (probes 8,4,6,5).
        a_val = 4'h5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort.probe3", {4'h0, probe}, 8'h06);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("abort", 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("abort.nodone%0d", i), {7'h0, done}, 8'h00);
        end
        rst = 1'b0;
        run("a5_after_rst", 4'h5, 4, 16'h8465, 4'h5, 1'b0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
